// File: rtl/rx_slot_manager_if.sv
// ---------------------------------------------------------------------------
// rx_slot_manager_if
// Purpose : bundles the RX MAC handshakes, the CPU head/pop handshake and the
//           status outputs of rx_slot_manager into one interface.
// Modports: slave  - the slot manager (consumes requests, drives status)
//           master - the environment (RX MAC / CPU side)
// Signals : alloc_req/alloc_gnt/alloc_nack/alloc_slot  slot allocation
//           done_valid/done_slot/done_len/done_err     frame completion
//           head_valid/head_slot/head_len/pop          ready queue head
//           rd_csb, rx_irq, drop_cnt, err_cnt          read selects / status
// ---------------------------------------------------------------------------
interface rx_slot_manager_if #(
    parameter int LEN_W = 11
);
    logic             alloc_req;
    logic             alloc_gnt;
    logic             alloc_nack;
    logic [1:0]       alloc_slot;
    logic             done_valid;
    logic [1:0]       done_slot;
    logic [LEN_W-1:0] done_len;
    logic             done_err;
    logic             head_valid;
    logic [1:0]       head_slot;
    logic [LEN_W-1:0] head_len;
    logic             pop;
    logic [3:0]       rd_csb;
    logic             rx_irq;
    logic [15:0]      drop_cnt;
    logic [15:0]      err_cnt;

    modport slave (
        input  alloc_req, done_valid, done_slot, done_len, done_err, pop,
        output alloc_gnt, alloc_nack, alloc_slot, head_valid, head_slot,
               head_len, rd_csb, rx_irq, drop_cnt, err_cnt
    );

    modport master (
        output alloc_req, done_valid, done_slot, done_len, done_err, pop,
        input  alloc_gnt, alloc_nack, alloc_slot, head_valid, head_slot,
               head_len, rd_csb, rx_irq, drop_cnt, err_cnt
    );
endinterface

// File: rtl/rx_slot_manager.sv
// ---------------------------------------------------------------------------
// rx_slot_manager
// Purpose : schedules the four RX SRAM banks as frame slots. Grants a FREE
//           slot to the RX MAC round-robin, queues completed good frames in
//           arrival order for the CPU, and frees a slot when the CPU pops it.
// Ports   : wb_clk_i - block clock
//           rst_n    - asynchronous active-low reset
//           bus      - rx_slot_manager_if.slave (allocation, completion,
//                      ready-queue head/pop, rd_csb, rx_irq, counters)
// Config  : RX_SLOT_STATS_EN - when defined, drop_cnt/err_cnt are saturating
//           16-bit counters; when undefined they are tied to zero.
// ---------------------------------------------------------------------------
module rx_slot_manager #(
    parameter int NSLOT = 4,
    parameter int LEN_W = 11
) (
    input  logic               wb_clk_i,
    input  logic               rst_n,
    rx_slot_manager_if.slave   bus
);
    typedef enum logic [1:0] {
        S_FREE    = 2'd0,
        S_FILLING = 2'd1,
        S_READY   = 2'd2
    } slot_state_e;

    slot_state_e      state_q [NSLOT];
    slot_state_e      state_d [NSLOT];
    logic [LEN_W-1:0] len_q   [NSLOT];
    logic [LEN_W-1:0] len_d   [NSLOT];
    logic [1:0]       fifo_q  [NSLOT];
    logic [1:0]       fifo_d  [NSLOT];
    logic [1:0]       rd_ptr_q, rd_ptr_d;
    logic [1:0]       wr_ptr_q, wr_ptr_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [1:0]       rr_q, rr_d;
    logic             alloc_gnt_q, alloc_gnt_d;
    logic             alloc_nack_q, alloc_nack_d;
    logic [1:0]       alloc_slot_q, alloc_slot_d;

    logic             found;
    logic [1:0]       sel;
    logic [1:0]       idx;
    logic             push;
    logic             pop_do;
    logic             head_valid;
    logic [1:0]       head_slot;

    assign head_valid = (cnt_q != 3'd0);
    assign head_slot  = fifo_q[rd_ptr_q];

    always_comb begin
        for (int i = 0; i < NSLOT; i++) begin
            state_d[i] = state_q[i];
            len_d[i]   = len_q[i];
            fifo_d[i]  = fifo_q[i];
        end
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        rr_d         = rr_q;
        alloc_gnt_d  = 1'b0;
        alloc_nack_d = 1'b0;
        alloc_slot_d = alloc_slot_q;
        found        = 1'b0;
        sel          = 2'd0;
        idx          = 2'd0;
        push         = 1'b0;
        pop_do       = 1'b0;

        // Search uses pre-edge state only, so a slot freed this cycle by a
        // pop or an errored completion is not grantable until next cycle.
        for (int i = 0; i < NSLOT; i++) begin
            idx = rr_q + 2'(i);
            if (!found && state_q[idx] == S_FREE) begin
                found = 1'b1;
                sel   = idx;
            end
        end

        if (bus.alloc_req) begin
            if (found) begin
                alloc_gnt_d    = 1'b1;
                alloc_slot_d   = sel;
                state_d[sel]   = S_FILLING;
                rr_d           = sel + 2'd1;
            end else begin
                alloc_nack_d   = 1'b1;
            end
        end

        // Granted slot was FREE and the completed slot is FILLING, so the
        // two updates never touch the same entry.
        if (bus.done_valid && state_q[bus.done_slot] == S_FILLING) begin
            if (!bus.done_err && bus.done_len != '0) begin
                state_d[bus.done_slot] = S_READY;
                len_d[bus.done_slot]   = bus.done_len;
                fifo_d[wr_ptr_q]       = bus.done_slot;
                wr_ptr_d               = wr_ptr_q + 2'd1;
                push                   = 1'b1;
            end else begin
                state_d[bus.done_slot] = S_FREE;
            end
        end

        // Pop decision uses pre-edge cnt: a push into an empty queue in the
        // same cycle cannot be popped immediately.
        if (bus.pop && head_valid) begin
            state_d[head_slot] = S_FREE;
            rd_ptr_d           = rd_ptr_q + 2'd1;
            pop_do             = 1'b1;
        end

        cnt_d = cnt_q + {2'b00, push} - {2'b00, pop_do};
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSLOT; i++) begin
                state_q[i] <= S_FREE;
                len_q[i]   <= '0;
                fifo_q[i]  <= 2'd0;
            end
            rd_ptr_q     <= 2'd0;
            wr_ptr_q     <= 2'd0;
            cnt_q        <= 3'd0;
            rr_q         <= 2'd0;
            alloc_gnt_q  <= 1'b0;
            alloc_nack_q <= 1'b0;
            alloc_slot_q <= 2'd0;
        end else begin
            for (int i = 0; i < NSLOT; i++) begin
                state_q[i] <= state_d[i];
                len_q[i]   <= len_d[i];
                fifo_q[i]  <= fifo_d[i];
            end
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            cnt_q        <= cnt_d;
            rr_q         <= rr_d;
            alloc_gnt_q  <= alloc_gnt_d;
            alloc_nack_q <= alloc_nack_d;
            alloc_slot_q <= alloc_slot_d;
        end
    end

    assign bus.alloc_gnt  = alloc_gnt_q;
    assign bus.alloc_nack = alloc_nack_q;
    assign bus.alloc_slot = alloc_slot_q;
    assign bus.head_valid = head_valid;
    assign bus.head_slot  = head_slot;
    assign bus.head_len   = len_q[head_slot];
    assign bus.rd_csb     = head_valid ? ~(4'b0001 << head_slot) : 4'hF;
    assign bus.rx_irq     = head_valid;

`ifdef RX_SLOT_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        err_ev;

    // Errored or empty completion of a FILLING slot
    assign err_ev = bus.done_valid && state_q[bus.done_slot] == S_FILLING &&
                    (bus.done_err || bus.done_len == '0);

    always_comb begin
        drop_cnt_d = alloc_nack_d ? sat_inc(drop_cnt_q) : drop_cnt_q;
        err_cnt_d  = err_ev ? sat_inc(err_cnt_q) : err_cnt_q;
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= 16'd0;
            err_cnt_q  <= 16'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.drop_cnt = drop_cnt_q;
    assign bus.err_cnt  = err_cnt_q;
`else
    assign bus.drop_cnt = 16'd0;
    assign bus.err_cnt  = 16'd0;
`endif
endmodule

// File: tb/tb_rx_slot_manager.sv
// ---------------------------------------------------------------------------
// tb_rx_slot_manager
// Scoreboard bench for rx_slot_manager: the driver applies stimulus, updates
// a slot/queue reference model at each clock edge and pushes the expected
// outputs; an independent monitor pops and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_rx_slot_manager;
`ifdef RX_SLOT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    rx_slot_manager_if #(.LEN_W(11)) bus ();

    rx_slot_manager #(.NSLOT(4), .LEN_W(11)) dut (
        .wb_clk_i (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit gnt;
        bit nack;
        int slot;
        bit hv;
        int hs;
        int hl;
        int csb;
        int drop;
        int err;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: 0 = FREE, 1 = FILLING, 2 = READY
    int st[4];
    int ln[4];
    int rq[$];
    int rr;
    int drop_m;
    int err_m;

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic exp_t snap(input bit g, input bit n, input int s);
        exp_t e;
        e.gnt  = g;
        e.nack = n;
        e.slot = s;
        e.hv   = (rq.size() != 0);
        e.hs   = e.hv ? rq[0] : 0;
        e.hl   = e.hv ? ln[rq[0]] : 0;
        e.csb  = e.hv ? ((~(1 << e.hs)) & 'hF) : 'hF;
        e.drop = STATS ? drop_m : 0;
        e.err  = STATS ? err_m : 0;
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            st[i] = 0;
            ln[i] = 0;
        end
        rq.delete();
        rr     = 0;
        drop_m = 0;
        err_m  = 0;
    endtask

    // Applies one clock edge of behaviour to the model from its pre-edge state.
    task automatic model_step(input bit req, input bit dv, input int ds,
                              input int dl, input bit de, input bit pp);
        int  pre[4];
        int  nst[4];
        int  pre_size;
        bit  g, n;
        int  gs;
        g = 0; n = 0; gs = 0;
        for (int i = 0; i < 4; i++) begin
            pre[i] = st[i];
            nst[i] = st[i];
        end
        pre_size = rq.size();
        if (req) begin
            for (int j = 0; j < 4; j++) begin
                if (!g && pre[(rr + j) % 4] == 0) begin
                    g  = 1;
                    gs = (rr + j) % 4;
                end
            end
            if (g) begin
                nst[gs] = 1;
                rr      = (gs + 1) % 4;
            end else begin
                n = 1;
                if (drop_m < 65535) drop_m++;
            end
        end
        if (pp && pre_size != 0) begin
            nst[rq[0]] = 0;
            void'(rq.pop_front());
        end
        if (dv && pre[ds] == 1) begin
            if (!de && dl != 0) begin
                nst[ds] = 2;
                ln[ds]  = dl;
                rq.push_back(ds);
            end else begin
                nst[ds] = 0;
                if (err_m < 65535) err_m++;
            end
        end
        for (int i = 0; i < 4; i++) st[i] = nst[i];
        exp_q.push_back(snap(g, n, gs));
    endtask

    // Called just after a falling edge; returns just after the next one.
    task automatic step(input bit req, input bit dv, input int ds,
                        input int dl, input bit de, input bit pp);
        bus.alloc_req  = req;
        bus.done_valid = dv;
        bus.done_slot  = 2'(ds);
        bus.done_len   = 11'(dl);
        bus.done_err   = de;
        bus.pop        = pp;
        @(posedge clk);
        model_step(req, dv, ds, dl, de, pp);
        @(negedge clk);
        #1;
        bus.alloc_req  = 1'b0;
        bus.done_valid = 1'b0;
        bus.pop        = 1'b0;
    endtask

    task automatic idle(); step(0, 0, 0, 0, 0, 0); endtask
    task automatic alloc(); step(1, 0, 0, 0, 0, 0); endtask
    task automatic done(input int s, input int l, input bit e); step(0, 1, s, l, e, 0); endtask
    task automatic popq(); step(0, 0, 0, 0, 0, 1); endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        bus.alloc_req  = 1'b0;
        bus.done_valid = 1'b0;
        bus.pop        = 1'b0;
        model_reset();
        #2;
        cmp("rst_gnt", bus.alloc_gnt, 0);
        cmp("rst_nack", bus.alloc_nack, 0);
        cmp("rst_alloc_slot", bus.alloc_slot, 0);
        cmp("rst_head_valid", bus.head_valid, 0);
        cmp("rst_head_slot", bus.head_slot, 0);
        cmp("rst_head_len", bus.head_len, 0);
        cmp("rst_csb", bus.rd_csb, 'hF);
        cmp("rst_irq", bus.rx_irq, 0);
        cmp("rst_drop", bus.drop_cnt, 0);
        cmp("rst_err", bus.err_cnt, 0);
        @(posedge clk);
        exp_q.push_back(snap(0, 0, 0));
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: one expected snapshot per driven edge, checked on the falling edge
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp("sb_gnt", bus.alloc_gnt, e.gnt);
            cmp("sb_nack", bus.alloc_nack, e.nack);
            if (e.gnt) cmp("sb_alloc_slot", bus.alloc_slot, e.slot);
            cmp("sb_head_valid", bus.head_valid, e.hv);
            if (e.hv) begin
                cmp("sb_head_slot", bus.head_slot, e.hs);
                cmp("sb_head_len", bus.head_len, e.hl);
            end
            cmp("sb_rd_csb", bus.rd_csb, e.csb);
            cmp("sb_rx_irq", bus.rx_irq, e.hv);
            cmp("sb_drop_cnt", bus.drop_cnt, e.drop);
            cmp("sb_err_cnt", bus.err_cnt, e.err);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        bus.alloc_req  = 1'b0;
        bus.done_valid = 1'b0;
        bus.done_slot  = 2'd0;
        bus.done_len   = 11'd0;
        bus.done_err   = 1'b0;
        bus.pop        = 1'b0;
        model_reset();
        do_reset();

        // Reset in the middle of frames, then fresh allocation order
        alloc(); alloc(); done(1, 99, 0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            alloc();
            cmp("rst_alloc_order", bus.alloc_slot, i);
        end

        // Fill and drain
        done(2, 64, 0); done(0, 1024, 0); done(1, 60, 0);
        cmp("fd_slot0", bus.head_slot, 2);
        cmp("fd_len0", bus.head_len, 64);
        cmp("fd_csb0", bus.rd_csb, 'hB);
        popq();
        cmp("fd_slot1", bus.head_slot, 0);
        cmp("fd_len1", bus.head_len, 1024);
        cmp("fd_csb1", bus.rd_csb, 'hE);
        popq();
        cmp("fd_slot2", bus.head_slot, 1);
        cmp("fd_len2", bus.head_len, 60);
        cmp("fd_csb2", bus.rd_csb, 'hD);
        popq();
        cmp("fd_irq_off", bus.rx_irq, 0);

        // Exhaustion (slot 3 is still FILLING)
        alloc(); alloc(); alloc();
        alloc();
        cmp("exh_nack", bus.alloc_nack, 1);
        cmp("exh_drop1", bus.drop_cnt, STATS ? 1 : 0);
        done(0, 100, 0);
        step(1, 0, 0, 0, 0, 1);
        cmp("exh_pop_nack", bus.alloc_nack, 1);
        alloc();
        cmp("exh_regrant", bus.alloc_gnt, 1);
        cmp("exh_regrant_slot", bus.alloc_slot, 0);
        alloc();
        cmp("exh_drop3", bus.drop_cnt, STATS ? 3 : 0);

        // Errors
        done(1, 200, 1);
        cmp("err_cnt1", bus.err_cnt, STATS ? 1 : 0);
        cmp("err_no_irq", bus.rx_irq, 0);
        done(2, 0, 0);
        cmp("err_cnt2", bus.err_cnt, STATS ? 2 : 0);
        done(1, 50, 0);
        cmp("err_free_ignored", bus.err_cnt, STATS ? 2 : 0);
        cmp("err_free_nohead", bus.head_valid, 0);

        // Simultaneous push/pop with one entry, then pops on an empty queue
        done(3, 200, 0);
        step(0, 1, 0, 300, 0, 1);
        cmp("pp_head_slot", bus.head_slot, 0);
        cmp("pp_head_len", bus.head_len, 300);
        popq();
        popq();
        cmp("pp_empty", bus.head_valid, 0);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            bit req, dv, de, pp;
            int ds, dl, r;
            int fill[$];
            if (k % 700 == 699) do_reset();
            fill.delete();
            for (int i = 0; i < 4; i++) if (st[i] == 1) fill.push_back(i);
            req = ($urandom % 3) == 0;
            dv  = 0;
            ds  = 0;
            if (fill.size() != 0 && ($urandom % 2) == 0) begin
                dv = 1;
                ds = fill[$urandom % fill.size()];
            end else if (($urandom % 8) == 0) begin
                dv = 1;
                ds = $urandom % 4;
            end
            r  = $urandom % 10;
            dl = (r == 0) ? 0 : (r == 1) ? 1024 : $urandom_range(1, 1023);
            de = ($urandom % 6) == 0;
            pp = ($urandom % 3) == 0;
            step(req, dv, ds, dl, de, pp);
        end

        idle();
        idle();
        cmp("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
